// File: rtl/skinny_mask_pkg.sv
// Shared constants, FSM encoding and seed-shift helper for the SKINNY mask RNG.
// Optional feature macro: MASK_RNG_OFF_EN (see skinny_mask_rng.sv).
package skinny_mask_pkg;
    localparam int LFSR_W      = 127;
    localparam int SEED_W      = 32;
    localparam int SEED_CHUNKS = 4;
    localparam int SBOX_RAND_W = 16;

    localparam int R1_OFS = 0;
    localparam int R2_OFS = 6;
    localparam int KL_OFS = 12;
    localparam int MN_OFS = 14;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        WARMUP,
        RUN
    } fsm_e;

    function automatic logic [LFSR_W-1:0] shift_chunk(
        input logic [LFSR_W-1:0] s,
        input logic [SEED_W-1:0] c
    );
        return {s[LFSR_W-SEED_W-1:0], c};
    endfunction
endpackage

// File: rtl/lfsr127_unroll.sv
// Combinational STEPS-fold unroll of the x^127+x+1 Fibonacci LFSR.
// Bit i of bits is the feedback bit produced on step i.
module lfsr127_unroll
    import skinny_mask_pkg::*;
#(
    parameter int STEPS = 256
) (
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_nxt,
    output logic [STEPS-1:0]  bits
);
    logic [LFSR_W-1:0] s;
    logic              fb;

    always_comb begin
        s    = state;
        fb   = 1'b0;
        bits = '0;
        for (int i = 0; i < STEPS; i++) begin
            fb      = s[LFSR_W-1] ^ s[LFSR_W-2];
            bits[i] = fb;
            s       = {s[LFSR_W-2:0], fb};
        end
        state_nxt = s;
    end
endmodule

// File: rtl/skinny_mask_rng.sv
// Fresh-randomness word source for the 3-share SKINNY S-box layer.
// Define MASK_RNG_OFF_EN to let rng_off force out_rand to zero.
module skinny_mask_rng
    import skinny_mask_pkg::*;
#(
    parameter int NUM_SBOX   = 16,
    parameter int WARMUP_CYC = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SEED_W-1:0]               seed_in,
    input  logic                            seed_valid,
    output logic                            seed_ready,
    output logic                            seed_err,
    output logic [SBOX_RAND_W*NUM_SBOX-1:0] out_rand,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            rng_off
);
    localparam int OUT_W = SBOX_RAND_W * NUM_SBOX;
    localparam int CNT_W = 8;

    fsm_e              fsm_q, fsm_d;
    logic [LFSR_W-1:0] state_q, state_d;
    logic [LFSR_W-1:0] step_state;
    logic [LFSR_W-1:0] chunk;
    logic [OUT_W-1:0]  rand_q, rand_d;
    logic [OUT_W-1:0]  step_bits;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    lfsr127_unroll #(
        .STEPS(OUT_W)
    ) u_lfsr (
        .state    (state_q),
        .state_nxt(step_state),
        .bits     (step_bits)
    );

    assign chunk = shift_chunk(state_q, seed_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rand_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rand_q  <= rand_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        rand_d     = rand_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        err_d      = err_q;
        seed_ready = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    state_d = chunk;
                    cnt_d   = CNT_W'(1);
                    fsm_d   = SEED;
                end
            end
            SEED: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    if (cnt_q == CNT_W'(SEED_CHUNKS - 1)) begin
                        // An all-zero state would lock the LFSR.
                        if (chunk == '0) begin
                            state_d = LFSR_W'(1);
                            err_d   = 1'b1;
                        end else begin
                            state_d = chunk;
                            err_d   = 1'b0;
                        end
                        cnt_d = '0;
                        fsm_d = WARMUP;
                    end else begin
                        state_d = chunk;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            WARMUP: begin
                state_d = step_state;
                rand_d  = step_bits;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WARMUP_CYC - 1)) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    state_d = chunk;
                    cnt_d   = CNT_W'(1);
                    valid_d = 1'b0;
                    fsm_d   = SEED;
                end else if (out_ready) begin
                    state_d = step_state;
                    rand_d  = step_bits;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign out_valid = valid_q;
    assign seed_err  = err_q;

`ifdef MASK_RNG_OFF_EN
    assign out_rand = rng_off ? '0 : rand_q;
`else
    logic unused_rng_off;
    assign unused_rng_off = rng_off;
    assign out_rand = rand_q;
`endif
endmodule

// File: tb/tb_skinny_mask_rng.sv
// Scoreboard bench for skinny_mask_rng against a bit-sequence LFSR model.
// Honours MASK_RNG_OFF_EN when deciding what rng_off should do.
module tb_skinny_mask_rng;
    localparam int NUM_SBOX   = 16;
    localparam int WARMUP_CYC = 4;
    localparam int OUT_W      = 16 * NUM_SBOX;

    logic             clk;
    logic             rst_n;
    logic [31:0]      seed_in;
    logic             seed_valid;
    logic             seed_ready;
    logic             seed_err;
    logic [OUT_W-1:0] out_rand;
    logic             out_valid;
    logic             out_ready;
    logic             rng_off;

    skinny_mask_rng #(
        .NUM_SBOX  (NUM_SBOX),
        .WARMUP_CYC(WARMUP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_in   (seed_in),
        .seed_valid(seed_valid),
        .seed_ready(seed_ready),
        .seed_err  (seed_err),
        .out_rand  (out_rand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rng_off   (rng_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [OUT_W-1:0] sb[$];
    logic [OUT_W-1:0] got[$];
    // Sequence a[n..n+126] of the recurrence a[m] = a[m-127] ^ a[m-126].
    bit seq[$];

    task automatic chk(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [OUT_W-1:0] model_word();
        logic [OUT_W-1:0] w;
        bit nb;
        w = '0;
        for (int b = 0; b < OUT_W; b++) begin
            nb = seq[0] ^ seq[1];
            void'(seq.pop_front());
            seq.push_back(nb);
            w[b] = nb;
        end
        return w;
    endfunction

    task automatic model_seed(input logic [127:0] c);
        logic [126:0] s;
        s = c[126:0];
        if (s == '0) s = 127'h1;
        seq.delete();
        for (int k = 0; k < 127; k++) seq.push_back(s[126-k]);
        repeat (WARMUP_CYC - 1) void'(model_word());
    endtask

    function automatic logic [OUT_W-1:0] exp_word(input logic [OUT_W-1:0] w);
`ifdef MASK_RNG_OFF_EN
        return rng_off ? '0 : w;
`else
        return w;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word got=%h want=none", out_rand);
            end else begin
                logic [OUT_W-1:0] e;
                e = sb.pop_front();
                got.push_back(out_rand);
                chk("word", out_rand, e);
            end
        end
    end

    task automatic send_chunk(input logic [31:0] d);
        int n;
        n = 0;
        seed_in    = d;
        seed_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!seed_ready && n < 50);
        if (!seed_ready) fail_now("seed_ready");
        @(posedge clk);
        #1;
        seed_valid = 1'b0;
    endtask

    task automatic seed4(input logic [127:0] c, input bit gaps);
        for (int i = 3; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_chunk(c[32*i+:32]);
        end
        model_seed(c);
    endtask

    task automatic wait_valid(input string name);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(name, OUT_W'(cyc), OUT_W'(WARMUP_CYC));
    endtask

    task automatic run_words(input int n, input bit rnd);
        int cnt;
        int cyc;
        for (int i = 0; i < n; i++) sb.push_back(exp_word(model_word()));
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("xfer_count", OUT_W'(cnt), OUT_W'(n));
        chk("sb_empty", OUT_W'(sb.size()), '0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        logic [OUT_W-1:0] w;
        rst_n      = 1'b0;
        seed_in    = '0;
        seed_valid = 1'b0;
        out_ready  = 1'b0;
        rng_off    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_held", OUT_W'(out_valid), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", OUT_W'(out_valid), '0);
        chk("rst_seed_ready", OUT_W'(seed_ready), OUT_W'(1));
        chk("rst_seed_err", OUT_W'(seed_err), '0);
        chk("rst_out_rand", out_rand, '0);
        @(posedge clk);
        #1;

        seed4(128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978, 1'b0);
        wait_valid("latency_golden");
        got.delete();
        run_words(3, 1'b0);
        if (got.size() == 3) begin
            chk("distinct01", OUT_W'(got[0] == got[1]), '0);
            chk("distinct02", OUT_W'(got[0] == got[2]), '0);
            chk("distinct12", OUT_W'(got[1] == got[2]), '0);
        end else fail_now("distinct_words");

        seed4(128'h0, 1'b0);
        chk("seed_err_set", OUT_W'(seed_err), OUT_W'(1));
        wait_valid("latency_zero");
        run_words(2, 1'b0);

        w = exp_word(model_word());
        sb.push_back(w);
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", OUT_W'(out_valid), OUT_W'(1));
            chk("stall_rand", out_rand, w);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_popped", OUT_W'(sb.size()), '0);
        run_words(2, 1'b0);

        sb.push_back(exp_word(model_word()));
        out_ready = 1'b1;
        send_chunk(32'hDEADBEEF);
        out_ready = 1'b0;
        @(negedge clk);
        chk("reseed_valid_drop", OUT_W'(out_valid), '0);
        chk("reseed_seed_ready", OUT_W'(seed_ready), OUT_W'(1));
        chk("reseed_concurrent_xfer", OUT_W'(sb.size()), '0);
        @(posedge clk);
        #1;
        send_chunk(32'h13579BDF);
        send_chunk(32'h2468ACE0);
        send_chunk(32'h0BADF00D);
        model_seed(128'hDEADBEEF_13579BDF_2468ACE0_0BADF00D);
        chk("seed_err_clear", OUT_W'(seed_err), '0);
        wait_valid("latency_reseed");
        run_words(3, 1'b1);

        seed4(128'h0, 1'b0);
        wait_valid("latency_zero2");
        chk("seed_err_again", OUT_W'(seed_err), OUT_W'(1));
        send_chunk(32'hCAFEF00D);
        send_chunk(32'h12345678);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", OUT_W'(out_valid), '0);
        chk("arst_seed_ready", OUT_W'(seed_ready), OUT_W'(1));
        chk("arst_seed_err", OUT_W'(seed_err), '0);
        chk("arst_out_rand", out_rand, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int it = 0; it < 4; it++) begin
            logic [127:0] c;
            c = {$urandom, $urandom, $urandom, $urandom};
            seed4(c, 1'b1);
            wait_valid("latency_rand");
            run_words(4, 1'b1);
        end

        rng_off = 1'b1;
        run_words(5, 1'b1);
        rng_off = 1'b0;
        run_words(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
